regfile_wb_sched: RTL and testbench

//  Owns the 15x64 Y86-64 register array and schedules writeback onto its single physical write port.

---
 rtl/y86_pkg.sv | 26 ++
 rtl/regfile_array.sv | 45 ++++
 rtl/regfile_wb_sched.sv | 123 ++++++++++++
 tb/tb_regfile_wb_sched.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register ids and the
// writeback scheduler state encoding.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_CMOVXX = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_WR_M = 1'b1
    } wb_state_t;

endpackage

// File: rtl/regfile_array.sv
// Architectural register storage: one synchronous write port and three
// asynchronous read ports. Index RNONE (and anything past NREGS) reads as 0
// and is never written.
module regfile_array
    import y86_pkg::*;
#(
    parameter int NREGS = 15,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [3:0]    wa,
    input  logic [DW-1:0] wd,
    input  logic [3:0]    ra_a,
    input  logic [3:0]    ra_b,
    input  logic [3:0]    ra_d,
    output logic [DW-1:0] rd_a,
    output logic [DW-1:0] rd_b,
    output logic [DW-1:0] rd_d
);

    logic [DW-1:0] regs [NREGS];

    function automatic logic [DW-1:0] rd(input logic [3:0] idx);
        logic [DW-1:0] v;
        v = '0;
        if (idx != RNONE && idx < 4'(NREGS)) v = regs[idx];
        return v;
    endfunction

    // Register array: cleared on reset, single write port otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && wa != RNONE && wa < 4'(NREGS)) begin
            regs[wa] <= wd;
        end
    end

    assign rd_a = rd(ra_a);
    assign rd_b = rd(ra_b);
    assign rd_d = rd(ra_d);

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: squashes not-taken conditional moves, serialises
// E/M writes onto the single array write port, forwards the pending M
// value to the decode read ports and counts physical commits.
module regfile_wb_sched
    import y86_pkg::*;
#(
    parameter int NREGS = 15,
    parameter int DW    = 64,
    parameter int CW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic [3:0]    wb_icode,
    input  logic          wb_cnd,
    input  logic [3:0]    wb_dstE,
    input  logic [DW-1:0] wb_valE,
    input  logic [3:0]    wb_dstM,
    input  logic [DW-1:0] wb_valM,
    input  logic [3:0]    srcA,
    input  logic [3:0]    srcB,
    output logic [DW-1:0] valA,
    output logic [DW-1:0] valB,
    output logic          busy,
    input  logic [3:0]    dbg_sel,
    output logic [DW-1:0] dbg_data,
    output logic [CW-1:0] commit_cnt
);

    wb_state_t     state, state_nxt;
    logic [3:0]    pend_dst;
    logic [DW-1:0] pend_val;
    logic [CW-1:0] cnt;
    logic [3:0]    eff_e, eff_m;
    logic          we, latch;
    logic [3:0]    wa;
    logic [DW-1:0] wd;
    logic [DW-1:0] arr_a, arr_b;

    // A not-taken cmovXX keeps its E destination from ever being written.
    assign eff_e = (wb_icode == ICODE_CMOVXX && !wb_cnd) ? RNONE : wb_dstE;
    assign eff_m = wb_dstM;

    assign wb_ready   = (state == WB_IDLE);
    assign busy       = (state == WB_WR_M);
    assign commit_cnt = cnt;

    // Write-port scheduling and next state; M wins when both target one reg.
    always_comb begin
        state_nxt = state;
        we        = 1'b0;
        wa        = RNONE;
        wd        = '0;
        latch     = 1'b0;
        unique case (state)
            WB_IDLE: begin
                if (wb_valid) begin
                    if (eff_e != RNONE && eff_m != RNONE && eff_e != eff_m) begin
                        we        = 1'b1;
                        wa        = eff_e;
                        wd        = wb_valE;
                        latch     = 1'b1;
                        state_nxt = WB_WR_M;
                    end else if (eff_m != RNONE) begin
                        we = 1'b1;
                        wa = eff_m;
                        wd = wb_valM;
                    end else if (eff_e != RNONE) begin
                        we = 1'b1;
                        wa = eff_e;
                        wd = wb_valE;
                    end
                end
            end
            WB_WR_M: begin
                we        = (pend_dst != RNONE);
                wa        = pend_dst;
                wd        = pend_val;
                state_nxt = WB_IDLE;
            end
            default: state_nxt = WB_IDLE;
        endcase
    end

    // State, pending M latch and commit counter; reset drops any pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WB_IDLE;
            pend_dst <= RNONE;
            pend_val <= '0;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (latch) begin
                pend_dst <= eff_m;
                pend_val <= wb_valM;
            end else if (state == WB_WR_M) begin
                pend_dst <= RNONE;
            end
            if (we && wa != RNONE) cnt <= cnt + CW'(1);
        end
    end

    regfile_array #(.NREGS(NREGS), .DW(DW)) u_array (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .wa   (wa),
        .wd   (wd),
        .ra_a (srcA),
        .ra_b (srcB),
        .ra_d (dbg_sel),
        .rd_a (arr_a),
        .rd_b (arr_b),
        .rd_d (dbg_data)
    );

    // Pending M value is visible to decode before it reaches the array.
    assign valA = (busy && srcA != RNONE && srcA == pend_dst) ? pend_val : arr_a;
    assign valB = (busy && srcB != RNONE && srcB == pend_dst) ? pend_val : arr_b;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for the writeback scheduler with a queue scoreboard.
module tb_regfile_wb_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready, w_ready;
    logic [3:0]  wb_icode;
    logic        wb_cnd;
    logic [3:0]  wb_dstE, wb_dstM;
    logic [63:0] wb_valE, wb_valM;
    logic [3:0]  srcA, srcB, dbg_sel;
    logic [63:0] valA, valB, dbg_data;
    logic [63:0] w_valA, w_valB, w_dbg;
    logic        busy, w_busy;
    logic [31:0] commit_cnt;
    logic [3:0]  w_cnt;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_cnt     = 0;

    always #5 clk = ~clk;

    regfile_wb_sched dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_icode(wb_icode), .wb_cnd(wb_cnd), .wb_dstE(wb_dstE), .wb_valE(wb_valE),
        .wb_dstM(wb_dstM), .wb_valM(wb_valM), .srcA(srcA), .srcB(srcB),
        .valA(valA), .valB(valB), .busy(busy), .dbg_sel(dbg_sel),
        .dbg_data(dbg_data), .commit_cnt(commit_cnt)
    );

    // Narrow-counter instance sees the same traffic; used to observe wrap.
    regfile_wb_sched #(.CW(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(w_ready),
        .wb_icode(wb_icode), .wb_cnd(wb_cnd), .wb_dstE(wb_dstE), .wb_valE(wb_valE),
        .wb_dstM(wb_dstM), .wb_valM(wb_valM), .srcA(srcA), .srcB(srcB),
        .valA(w_valA), .valB(w_valB), .busy(w_busy), .dbg_sel(dbg_sel),
        .dbg_data(w_dbg), .commit_cnt(w_cnt)
    );

    task automatic push(input string t, input logic [63:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [63:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_underflow observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Present one request for a single clock; returns #1 after the edge.
    task automatic send(input logic [3:0] ic, input logic c,
                        input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm);
        @(negedge clk);
        wb_valid = 1'b1; wb_icode = ic; wb_cnd = c;
        wb_dstE = de; wb_valE = ve; wb_dstM = dm; wb_valM = vm;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; wb_valid = 1'b0; wb_icode = 4'h1; wb_cnd = 1'b0;
        wb_dstE = 4'hF; wb_valE = '0; wb_dstM = 4'hF; wb_valM = '0;
        srcA = 4'hF; srcB = 4'hF; dbg_sel = 4'hF;
        #12 rst_n = 1'b1;

        // 1: preload, then asynchronous reset mid-cycle
        send(4'h3, 1'b0, 4'h5, 64'hAA, 4'hF, 64'h0);
        send(4'h3, 1'b0, 4'h3, 64'hBB, 4'hF, 64'h0);
        srcA = 4'h5; srcB = 4'h3; dbg_sel = 4'h5; #1;
        push("preload_valA", 64'hAA);
        pop_chk(valA);
        pulse_reset();
        push("rst_valA", 64'h0);
        push("rst_valB", 64'h0);
        push("rst_dbg", 64'h0);
        push("rst_cnt", 64'h0);
        push("rst_ready", 64'h1);
        pop_chk(valA); pop_chk(valB); pop_chk(dbg_data);
        pop_chk(64'(commit_cnt)); pop_chk(64'(wb_ready));
        release_reset();

        // 2: irmovq to %rdx
        srcA = 4'h2;
        send(4'h3, 1'b0, 4'h2, 64'h1234, 4'hF, 64'h0);
        exp_cnt++;
        push("irmovq_valA", 64'h1234);
        push("irmovq_cnt", 64'(exp_cnt));
        push("irmovq_busy", 64'h0);
        pop_chk(valA); pop_chk(64'(commit_cnt)); pop_chk(64'(busy));

        // RNONE read port returns zero
        srcA = 4'hF; #1;
        push("rnone_read", 64'h0);
        pop_chk(valA);

        // 3: popq %rbx, forwarding while M is pending
        srcA = 4'h4; srcB = 4'h3; dbg_sel = 4'h3;
        send(4'hB, 1'b0, 4'h4, 64'h108, 4'h3, 64'hDEAD);
        exp_cnt++;
        push("popq_rsp", 64'h108);
        push("popq_busy", 64'h1);
        push("popq_ready", 64'h0);
        push("popq_fwd_valB", 64'hDEAD);
        push("popq_dbg_raw", 64'h0);
        push("popq_cnt1", 64'(exp_cnt));
        pop_chk(valA); pop_chk(64'(busy)); pop_chk(64'(wb_ready));
        pop_chk(valB); pop_chk(dbg_data); pop_chk(64'(commit_cnt));
        // a request offered during WR_M must be ignored
        send(4'h3, 1'b0, 4'h6, 64'h66, 4'hF, 64'h0);
        exp_cnt++;
        push("popq_dbg_commit", 64'hDEAD);
        push("popq_busy2", 64'h0);
        push("popq_ready2", 64'h1);
        push("popq_cnt2", 64'(exp_cnt));
        pop_chk(dbg_data); pop_chk(64'(busy)); pop_chk(64'(wb_ready));
        pop_chk(64'(commit_cnt));
        dbg_sel = 4'h6; #1;
        push("wrm_input_ignored", 64'h0);
        pop_chk(dbg_data);

        // 4: popq %rsp, M wins in a single cycle
        send(4'hB, 1'b0, 4'h4, 64'h108, 4'h4, 64'h55);
        exp_cnt++;
        push("popq_rsp_val", 64'h55);
        push("popq_rsp_busy", 64'h0);
        push("popq_rsp_cnt", 64'(exp_cnt));
        pop_chk(valA); pop_chk(64'(busy)); pop_chk(64'(commit_cnt));

        // both destinations RNONE: nothing committed
        send(4'h1, 1'b0, 4'hF, 64'h9, 4'hF, 64'h9);
        push("nop_cnt", 64'(exp_cnt));
        pop_chk(64'(commit_cnt));

        // 5: cmovle not taken, then taken; cnd ignored for other icodes
        srcA = 4'h1;
        send(4'h2, 1'b0, 4'h1, 64'h7, 4'hF, 64'h0);
        push("cmov_nt_reg", 64'h0);
        push("cmov_nt_cnt", 64'(exp_cnt));
        pop_chk(valA); pop_chk(64'(commit_cnt));
        send(4'h2, 1'b1, 4'h1, 64'h7, 4'hF, 64'h0);
        exp_cnt++;
        push("cmov_t_reg", 64'h7);
        push("cmov_t_cnt", 64'(exp_cnt));
        pop_chk(valA); pop_chk(64'(commit_cnt));
        srcB = 4'h7;
        send(4'h6, 1'b0, 4'h7, 64'h77, 4'hF, 64'h0);
        exp_cnt++;
        push("opq_cnd0_reg", 64'h77);
        pop_chk(valB);

        // 6: reset while M write pending drops it
        pulse_reset();
        release_reset();
        dbg_sel = 4'h3; srcB = 4'h3;
        send(4'hB, 1'b0, 4'h4, 64'h108, 4'h3, 64'hDEAD);
        exp_cnt++;
        push("rstwrm_busy_pre", 64'h1);
        pop_chk(64'(busy));
        pulse_reset();
        push("rstwrm_busy", 64'h0);
        push("rstwrm_ready", 64'h1);
        push("rstwrm_valB", 64'h0);
        push("rstwrm_cnt", 64'h0);
        pop_chk(64'(busy)); pop_chk(64'(wb_ready)); pop_chk(valB);
        pop_chk(64'(commit_cnt));
        release_reset();
        @(posedge clk); @(posedge clk); #1;
        push("rstwrm_reg3", 64'h0);
        pop_chk(dbg_data);

        // counter wrap on the narrow-counter instance
        for (int i = 0; i < 15; i++) begin
            send(4'h3, 1'b0, 4'(i % 15), 64'(i + 1), 4'hF, 64'h0);
            exp_cnt++;
        end
        push("wrap_max", 64'(exp_cnt[3:0]));
        pop_chk(64'(w_cnt));
        send(4'h3, 1'b0, 4'h0, 64'h1, 4'hF, 64'h0);
        exp_cnt++;
        push("wrap_zero", 64'(exp_cnt[3:0]));
        push("wide_cnt", 64'(exp_cnt));
        pop_chk(64'(w_cnt)); pop_chk(64'(commit_cnt));

        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
